// File: rtl/ifu_pkg.sv
// Shared IFU constants and the set-associative cache FSM encoding.
package ifu_pkg;

  localparam logic VALID = 1'b1;
  localparam logic HIT   = 1'b1;

  typedef logic [2:0] t_ifu_sa_state;

  localparam t_ifu_sa_state IDLE      = 3'd0;
  localparam t_ifu_sa_state LOOKUP    = 3'd1;
  localparam t_ifu_sa_state MISS_REQ  = 3'd2;
  localparam t_ifu_sa_state MISS_WAIT = 3'd3;
  localparam t_ifu_sa_state FLUSH     = 3'd4;

endpackage

// File: rtl/ifu_plru_tree.sv
// Combinational tree-PLRU for one set: victim walk and access update.
module ifu_plru_tree #(
  parameter  int NUM_WAYS = 4,
  localparam int P_BITS   = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree,
  input  logic [P_BITS-1:0]   accessWay,
  input  logic                accessValid,
  output logic [P_BITS-1:0]   victimWay,
  output logic [NUM_WAYS-2:0] nextTree
);

  always_comb begin : victim_walk
    int node;
    node      = 0;
    victimWay = '0;
    for (int l = 0; l < P_BITS; l++) begin
      victimWay = P_BITS'({victimWay, tree[node[P_BITS-1:0]]});
      node = 2 * node + 1 + int'(tree[node[P_BITS-1:0]]);
    end
  end

  // each node on the accessed way's path is turned to point away from it
  always_comb begin : update_walk
    int node;
    int dir;
    node     = 0;
    dir      = 0;
    nextTree = tree;
    if (accessValid) begin
      for (int l = 0; l < P_BITS; l++) begin
        dir = int'(accessWay >> (P_BITS - 1 - l)) & 1;
        nextTree[node[P_BITS-1:0]] = (dir == 0);
        node = 2 * node + 1 + dir;
      end
    end
  end

endmodule

// File: rtl/ifu_sa_cache.sv
// Set-associative IFU instruction cache with PLRU, miss FSM and flush.
module ifu_sa_cache
  import ifu_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 32,
  parameter  int OFFSET_WIDTH = 4,
  parameter  int NUM_SETS     = 4,
  parameter  int NUM_WAYS     = 4,
  localparam int LINE_WIDTH   = 8 << OFFSET_WIDTH,
  localparam int SET_WIDTH    = $clog2(NUM_SETS),
  localparam int LADDR_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Rst,
  input  logic                   cpu_reqValidIn,
  input  logic [ADDR_WIDTH-1:0]  cpu_reqAddrIn,
  output logic                   cpu_reqReadyOut,
  output logic                   cpu_rspValidOut,
  output logic [ADDR_WIDTH-1:0]  cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0]  cpu_rspInsLineOut,
  output logic                   mem_reqValidOut,
  output logic [LADDR_WIDTH-1:0] mem_reqLineAddrOut,
  input  logic                   mem_reqReadyIn,
  input  logic                   mem_rspValidIn,
  input  logic [LADDR_WIDTH-1:0] mem_rspLineAddrIn,
  input  logic [LINE_WIDTH-1:0]  mem_rspInsLineIn,
  input  logic                   flushIn,
  output logic                   hitStatusOut,
  output logic [15:0]            missCountOut
);

  localparam int P_BITS    = $clog2(NUM_WAYS);
  localparam int TAG_WIDTH = LADDR_WIDTH - SET_WIDTH;
  localparam int SIDX_W    = (SET_WIDTH > 0) ? SET_WIDTH : 1;

  typedef logic [TAG_WIDTH-1:0]  t_tag;
  typedef logic [LINE_WIDTH-1:0] t_line;
  typedef logic [NUM_WAYS-2:0]   t_tree;

  t_ifu_sa_state         state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  t_line                 rsp_line_q, rsp_line_d;
  logic                  mem_req_q, mem_req_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  t_tree               plru_q  [NUM_SETS];
  t_tag                tag_q   [NUM_SETS][NUM_WAYS];
  t_line               data_q  [NUM_SETS][NUM_WAYS];

  logic [SIDX_W-1:0] set_idx;
  t_tag              req_tag;
  logic              hit;
  logic [P_BITS-1:0] hit_way;
  logic              has_inv;
  logic [P_BITS-1:0] inv_way;
  logic [P_BITS-1:0] plru_victim;
  logic [P_BITS-1:0] fill_way;
  logic [P_BITS-1:0] access_way;
  t_tree             plru_next;
  logic              hit_en;
  logic              fill_en;
  logic              flush_en;
  logic              req_fire;
  logic              rsp_match;

  if (SET_WIDTH > 0) begin : g_set
    assign set_idx = req_addr_q[OFFSET_WIDTH +: SIDX_W];
  end else begin : g_noset
    assign set_idx = '0;
  end

  assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_fire  = cpu_reqValidIn && cpu_reqReadyOut;
  assign rsp_match = mem_rspValidIn &&
    (mem_rspLineAddrIn == req_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH]);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = P_BITS'(w);
      end
      if (!valid_q[set_idx][w]) begin
        has_inv = 1'b1;
        inv_way = P_BITS'(w);
      end
    end
  end

  assign fill_way   = has_inv ? inv_way : plru_victim;
  assign access_way = fill_en ? fill_way : hit_way;

  ifu_plru_tree #(
    .NUM_WAYS(NUM_WAYS)
  ) u_plru (
    .tree       (plru_q[set_idx]),
    .accessWay  (access_way),
    .accessValid(hit_en || fill_en),
    .victimWay  (plru_victim),
    .nextTree   (plru_next)
  );

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    flush_pend_d = flush_pend_q || (flushIn && state_q != IDLE);
    miss_cnt_d   = miss_cnt_q;
    rsp_valid_d  = 1'b0;
    hit_d        = 1'b0;
    rsp_addr_d   = rsp_addr_q;
    rsp_line_d   = rsp_line_q;
    mem_req_d    = mem_req_q;
    hit_en       = 1'b0;
    fill_en      = 1'b0;
    flush_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          req_addr_d = cpu_reqAddrIn;
          state_d    = LOOKUP;
          if (flushIn) flush_pend_d = 1'b1;
        end else if (flush_pend_q || flushIn) begin
          state_d = FLUSH;
        end
      end
      LOOKUP: begin
        if (hit) begin
          hit_en      = 1'b1;
          rsp_valid_d = 1'b1;
          hit_d       = HIT;
          rsp_addr_d  = req_addr_q;
          rsp_line_d  = data_q[set_idx][hit_way];
          state_d     = IDLE;
        end else begin
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          mem_req_d = 1'b1;
          state_d   = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_reqReadyIn) begin
          mem_req_d = 1'b0;
          state_d   = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (rsp_match) begin
          fill_en     = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = req_addr_q;
          rsp_line_d  = mem_rspInsLineIn;
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        flush_en     = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      miss_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      hit_q        <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_line_q   <= '0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      flush_pend_q <= flush_pend_d;
      miss_cnt_q   <= miss_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      hit_q        <= hit_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_line_q   <= rsp_line_d;
      mem_req_q    <= mem_req_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst || flush_en) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (hit_en || fill_en) plru_q[set_idx] <= plru_next;
      if (fill_en) valid_q[set_idx][fill_way] <= VALID;
    end
  end

  // tags and data survive flush; only valid bits gate their use
  always_ff @(posedge Clock) begin
    if (fill_en) begin
      tag_q[set_idx][fill_way]  <= req_tag;
      data_q[set_idx][fill_way] <= mem_rspInsLineIn;
    end
  end

  assign cpu_reqReadyOut    = (state_q == IDLE) && !flush_pend_q && !Rst;
  assign cpu_rspValidOut    = rsp_valid_q;
  assign cpu_rspAddrOut     = rsp_addr_q;
  assign cpu_rspInsLineOut  = rsp_line_q;
  assign mem_reqValidOut    = mem_req_q;
  assign mem_reqLineAddrOut = req_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign hitStatusOut       = hit_q;
  assign missCountOut       = miss_cnt_q;

endmodule

// File: tb/tb_ifu_sa_cache.sv
// Randomized self-checking bench for ifu_sa_cache with a 4x4 reference model.
module tb_ifu_sa_cache;

  logic         Clock = 1'b0;
  logic         Rst = 1'b1;
  logic         cpu_reqValidIn = 1'b0;
  logic [31:0]  cpu_reqAddrIn = '0;
  logic         cpu_reqReadyOut;
  logic         cpu_rspValidOut;
  logic [31:0]  cpu_rspAddrOut;
  logic [127:0] cpu_rspInsLineOut;
  logic         mem_reqValidOut;
  logic [27:0]  mem_reqLineAddrOut;
  logic         mem_reqReadyIn = 1'b0;
  logic         mem_rspValidIn = 1'b0;
  logic [27:0]  mem_rspLineAddrIn = '0;
  logic [127:0] mem_rspInsLineIn = '0;
  logic         flushIn = 1'b0;
  logic         hitStatusOut;
  logic [15:0]  missCountOut;

  int n_chk = 0;
  int n_pass = 0;

  bit          m_val  [4][4];
  logic [27:0] m_la   [4][4];
  bit          m_root [4];
  bit          m_lft  [4];
  bit          m_rgt  [4];
  int          m_miss;

  ifu_sa_cache dut (
    .Clock             (Clock),
    .Rst               (Rst),
    .cpu_reqValidIn    (cpu_reqValidIn),
    .cpu_reqAddrIn     (cpu_reqAddrIn),
    .cpu_reqReadyOut   (cpu_reqReadyOut),
    .cpu_rspValidOut   (cpu_rspValidOut),
    .cpu_rspAddrOut    (cpu_rspAddrOut),
    .cpu_rspInsLineOut (cpu_rspInsLineOut),
    .mem_reqValidOut   (mem_reqValidOut),
    .mem_reqLineAddrOut(mem_reqLineAddrOut),
    .mem_reqReadyIn    (mem_reqReadyIn),
    .mem_rspValidIn    (mem_rspValidIn),
    .mem_rspLineAddrIn (mem_rspLineAddrIn),
    .mem_rspInsLineIn  (mem_rspInsLineIn),
    .flushIn           (flushIn),
    .hitStatusOut      (hitStatusOut),
    .missCountOut      (missCountOut)
  );

  always #5 Clock = ~Clock;

  function automatic logic [127:0] line_data(input logic [27:0] la);
    logic [31:0] h;
    if (la == 28'h100) return {16{8'hA5}};
    h = {4'h0, la} * 32'h9E3779B1;
    return {h, ~h, h ^ 32'h5A5A5A5A, {4'h0, la}};
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) m_val[s][w] = 1'b0;
      m_root[s] = 1'b0;
      m_lft[s]  = 1'b0;
      m_rgt[s]  = 1'b0;
    end
  endfunction

  function automatic int m_find(input logic [27:0] la);
    int s;
    s = int'(la[1:0]);
    for (int w = 0; w < 4; w++)
      if (m_val[s][w] && m_la[s][w] == la) return w;
    return -1;
  endfunction

  // 4-way tree: root picks half, m_lft/m_rgt pick within each pair
  function automatic int m_victim(input int s);
    for (int w = 0; w < 4; w++)
      if (!m_val[s][w]) return w;
    if (!m_root[s]) return m_lft[s] ? 1 : 0;
    return m_rgt[s] ? 3 : 2;
  endfunction

  function automatic void m_touch(input int s, input int w);
    m_root[s] = (w < 2);
    if (w < 2) m_lft[s] = (w == 0);
    else       m_rgt[s] = (w == 2);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    #1;
    m_flush();
    m_miss = 0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!cpu_reqReadyOut && t < 20) begin
      tick();
      t++;
    end
    n_chk++;
    if (cpu_reqReadyOut !== 1'b1)
      $display("FAIL ready_wait got %b want 1", cpu_reqReadyOut);
    else n_pass++;
  endtask

  task automatic fetch(input logic [31:0] addr, input int rdy_dly,
                       input int rsp_dly, input bit bogus, input bit flsh);
    logic [27:0] la;
    int s, w, v;
    la = addr[31:4];
    s  = int'(la[1:0]);
    wait_ready();
    cpu_reqValidIn = 1'b1;
    cpu_reqAddrIn  = addr;
    tick();
    cpu_reqValidIn = 1'b0;
    cpu_reqAddrIn  = $urandom;
    n_chk++;
    if (cpu_rspValidOut !== 1'b0 || mem_reqValidOut !== 1'b0)
      $display("FAIL lookup_quiet rsp=%b mreq=%b want 0/0",
               cpu_rspValidOut, mem_reqValidOut);
    else n_pass++;
    w = m_find(la);
    tick();
    if (w >= 0) begin
      m_touch(s, w);
      n_chk++;
      if ({cpu_rspValidOut, hitStatusOut, cpu_reqReadyOut, mem_reqValidOut}
          !== 4'b1110)
        $display("FAIL hit_flags addr=%h got rsp/hit/rdy/mreq=%b%b%b%b want 1110",
                 addr, cpu_rspValidOut, hitStatusOut, cpu_reqReadyOut,
                 mem_reqValidOut);
      else n_pass++;
      n_chk++;
      if (cpu_rspInsLineOut !== line_data(la) || cpu_rspAddrOut !== addr ||
          missCountOut !== 16'(m_miss))
        $display("FAIL hit_data addr=%h got %h/%h/%0d want %h/%h/%0d", addr,
                 cpu_rspInsLineOut, cpu_rspAddrOut, missCountOut,
                 line_data(la), addr, m_miss);
      else n_pass++;
    end else begin
      m_miss++;
      n_chk++;
      if (mem_reqValidOut !== 1'b1 || mem_reqLineAddrOut !== la ||
          cpu_rspValidOut !== 1'b0 || missCountOut !== 16'(m_miss))
        $display("FAIL miss_req addr=%h got v=%b la=%h rsp=%b cnt=%0d want 1/%h/0/%0d",
                 addr, mem_reqValidOut, mem_reqLineAddrOut, cpu_rspValidOut,
                 missCountOut, la, m_miss);
      else n_pass++;
      for (int i = 0; i < rdy_dly; i++) begin
        mem_rspValidIn    = bogus;
        mem_rspLineAddrIn = la;
        mem_rspInsLineIn  = '1;
        tick();
        n_chk++;
        if (mem_reqValidOut !== 1'b1 || mem_reqLineAddrOut !== la ||
            cpu_rspValidOut !== 1'b0)
          $display("FAIL req_hold cyc=%0d got v=%b la=%h rsp=%b want 1/%h/0",
                   i, mem_reqValidOut, mem_reqLineAddrOut, cpu_rspValidOut, la);
        else n_pass++;
      end
      mem_rspValidIn = 1'b0;
      mem_reqReadyIn = 1'b1;
      tick();
      mem_reqReadyIn = 1'b0;
      n_chk++;
      if (mem_reqValidOut !== 1'b0)
        $display("FAIL req_drop got %b want 0", mem_reqValidOut);
      else n_pass++;
      if (flsh) begin
        flushIn = 1'b1;
        tick();
        flushIn = 1'b0;
      end
      for (int i = 0; i < rsp_dly; i++) tick();
      if (bogus) begin
        mem_rspValidIn    = 1'b1;
        mem_rspLineAddrIn = la ^ 28'h2FF;
        mem_rspInsLineIn  = {4{$urandom}};
        tick();
        mem_rspValidIn = 1'b0;
        n_chk++;
        if (cpu_rspValidOut !== 1'b0)
          $display("FAIL bogus_rsp got %b want 0", cpu_rspValidOut);
        else n_pass++;
      end
      mem_rspValidIn    = 1'b1;
      mem_rspLineAddrIn = la;
      mem_rspInsLineIn  = line_data(la);
      tick();
      mem_rspValidIn = 1'b0;
      n_chk++;
      if (cpu_rspValidOut !== 1'b1 || hitStatusOut !== 1'b0 ||
          cpu_rspInsLineOut !== line_data(la) || cpu_rspAddrOut !== addr)
        $display("FAIL fill_rsp addr=%h got v=%b h=%b %h/%h want 1/0 %h/%h",
                 addr, cpu_rspValidOut, hitStatusOut, cpu_rspInsLineOut,
                 cpu_rspAddrOut, line_data(la), addr);
      else n_pass++;
      v = m_victim(s);
      m_val[s][v] = 1'b1;
      m_la[s][v]  = la;
      m_touch(s, v);
      n_chk++;
      if (cpu_reqReadyOut !== !flsh)
        $display("FAIL fill_ready got %b want %b", cpu_reqReadyOut, !flsh);
      else n_pass++;
      tick();
      n_chk++;
      if (cpu_rspValidOut !== 1'b0)
        $display("FAIL rsp_pulse got %b want 0", cpu_rspValidOut);
      else n_pass++;
      if (flsh) begin
        n_chk++;
        if (cpu_reqReadyOut !== 1'b0)
          $display("FAIL flush_busy got %b want 0", cpu_reqReadyOut);
        else n_pass++;
        tick();
        n_chk++;
        if (cpu_reqReadyOut !== 1'b1)
          $display("FAIL flush_done got %b want 1", cpu_reqReadyOut);
        else n_pass++;
        m_flush();
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (cpu_reqReadyOut !== 1'b0)
      $display("FAIL reset_ready_hi got %b want 0", cpu_reqReadyOut);
    else n_pass++;
    n_chk++;
    if ({cpu_rspValidOut, hitStatusOut, mem_reqValidOut} !== 3'b000 ||
        missCountOut !== 16'd0 || cpu_rspAddrOut !== 32'd0 ||
        cpu_rspInsLineOut !== 128'd0)
      $display("FAIL reset_outs got %b%b%b cnt=%0d addr=%h line=%h want zeros",
               cpu_rspValidOut, hitStatusOut, mem_reqValidOut, missCountOut,
               cpu_rspAddrOut, cpu_rspInsLineOut);
    else n_pass++;
    Rst = 1'b0;
    #1;
    n_chk++;
    if (cpu_reqReadyOut !== 1'b1)
      $display("FAIL reset_ready_lo got %b want 1", cpu_reqReadyOut);
    else n_pass++;
    m_flush();
    m_miss = 0;
  endtask

  task automatic test_cold_miss();
    fetch(32'h1000, 0, 3, 1'b0, 1'b0);
    n_chk++;
    if (missCountOut !== 16'd1)
      $display("FAIL cold_count got %0d want 1", missCountOut);
    else n_pass++;
    fetch(32'h1000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_plru();
    reset_dut();
    fetch(32'h000, 0, 0, 1'b0, 1'b0);
    fetch(32'h040, 0, 0, 1'b0, 1'b0);
    fetch(32'h080, 0, 0, 1'b0, 1'b0);
    fetch(32'h0C0, 0, 0, 1'b0, 1'b0);
    fetch(32'h000, 0, 0, 1'b0, 1'b0);
    fetch(32'h100, 0, 0, 1'b0, 1'b0);
    fetch(32'h000, 0, 0, 1'b0, 1'b0);
    fetch(32'h040, 0, 0, 1'b0, 1'b0);
    fetch(32'h0C0, 0, 0, 1'b0, 1'b0);
    n_chk++;
    if (missCountOut !== 16'd5)
      $display("FAIL plru_count_a got %0d want 5", missCountOut);
    else n_pass++;
    fetch(32'h080, 0, 0, 1'b0, 1'b0);
    n_chk++;
    if (missCountOut !== 16'd6)
      $display("FAIL plru_count_b got %0d want 6", missCountOut);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    reset_dut();
    fetch(32'h1000, 0, 1, 1'b1, 1'b0);
    fetch(32'h1008, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fetch(32'h2050, 5, 0, 1'b1, 1'b0);
    fetch(32'h2054, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    fetch(32'h3070, 0, 1, 1'b0, 1'b1);
    fetch(32'h3070, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      fetch((i % 2 == 0) ? 32'h3070 : 32'h2050, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_flush();
    wait_ready();
    flushIn = 1'b1;
    tick();
    flushIn = 1'b0;
    n_chk++;
    if (cpu_reqReadyOut !== 1'b0)
      $display("FAIL idle_flush_busy got %b want 0", cpu_reqReadyOut);
    else n_pass++;
    tick();
    m_flush();
  endtask

  task automatic test_reset_abort();
    logic [27:0] la;
    la = 28'h234;
    for (int st = 0; st < 2; st++) begin
      wait_ready();
      cpu_reqValidIn = 1'b1;
      cpu_reqAddrIn  = {la, 4'h0};
      tick();
      cpu_reqValidIn = 1'b0;
      tick();
      if (st == 1) begin
        mem_reqReadyIn = 1'b1;
        tick();
        mem_reqReadyIn = 1'b0;
      end
      Rst = 1'b1;
      tick();
      n_chk++;
      if (mem_reqValidOut !== 1'b0 || cpu_rspValidOut !== 1'b0)
        $display("FAIL abort_rst st=%0d got mreq=%b rsp=%b want 0/0",
                 st, mem_reqValidOut, cpu_rspValidOut);
      else n_pass++;
      Rst = 1'b0;
      mem_rspValidIn    = 1'b1;
      mem_rspLineAddrIn = la;
      mem_rspInsLineIn  = line_data(la);
      tick();
      mem_rspValidIn = 1'b0;
      n_chk++;
      if (cpu_rspValidOut !== 1'b0 || missCountOut !== 16'd0 ||
          cpu_reqReadyOut !== 1'b1)
        $display("FAIL abort_late st=%0d got rsp=%b cnt=%0d rdy=%b want 0/0/1",
                 st, cpu_rspValidOut, missCountOut, cpu_reqReadyOut);
      else n_pass++;
      m_flush();
      m_miss = 0;
    end
    fetch({la, 4'h0}, 0, 0, 1'b0, 1'b0);
    n_chk++;
    if (missCountOut !== 16'd1)
      $display("FAIL abort_refetch got %0d want 1", missCountOut);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [27:0] la;
    for (int i = 0; i < 80; i++) begin
      la = 28'h400 + 28'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) test_idle_flush();
      fetch({la, 4'($urandom_range(0, 15))}, $urandom_range(0, 2),
            $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_plru();
    test_mismatch();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_idle_flush();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
